// File: rtl/md_seq_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer for the HI/LO datapath.
// Shift-add multiply, restoring divide, one step per cycle.
module md_seq_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              cancel,
    output logic              stall_req,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic              div_by_zero
);

    localparam int CW = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] acc_nxt;
    logic [DATA_W-1:0]   dsr;
    logic                is_div;
    logic                res_neg;
    logic                rem_neg;

    logic                op_div;
    logic                sign_a;
    logic                sign_b;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;

    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     shl;
    logic [DATA_W:0]     diff;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    // Decode the incoming op and take operand magnitudes for signed ops
    always_comb begin
        op_div = op[1];
        sign_a = ~op[0] & src_a[DATA_W-1];
        sign_b = ~op[0] & src_b[DATA_W-1];
        mag_a  = sign_a ? -src_a : src_a;
        mag_b  = sign_b ? -src_b : src_b;
    end

    // One shift-add or restoring-divide step, plus final sign correction
    always_comb begin
        sum     = '0;
        shl     = '0;
        diff    = '0;
        acc_nxt = acc;
        unique case (1'b1)
            is_div: begin
                shl  = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
                diff = shl - {1'b0, dsr};
                if (!diff[DATA_W])
                    acc_nxt = {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
                else
                    acc_nxt = {shl[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
            end
            default: begin
                sum = {1'b0, acc[2*DATA_W-1:DATA_W]}
                    + {1'b0, (acc[0] ? dsr : {DATA_W{1'b0}})};
                acc_nxt = {sum, acc[DATA_W-1:1]};
            end
        endcase
        prod_fix = res_neg ? -acc_nxt : acc_nxt;
        quo_fix  = res_neg ? -acc_nxt[DATA_W-1:0]
                           : acc_nxt[DATA_W-1:0];
        rem_fix  = rem_neg ? -acc_nxt[2*DATA_W-1:DATA_W]
                           : acc_nxt[2*DATA_W-1:DATA_W];
    end

    // Stall while a request is being accepted or an op is iterating
    assign stall_req = resetn
                     & (((state == IDLE) & start & ~cancel)
                        | (state == CALC));

    assign busy = (state != IDLE);

    // Sequencer FSM with registered results and done pulse
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            dsr         <= '0;
            is_div      <= 1'b0;
            res_neg     <= 1'b0;
            rem_neg     <= 1'b0;
            done        <= 1'b0;
            hi_out      <= '0;
            lo_out      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        is_div  <= op_div;
                        res_neg <= sign_a ^ sign_b;
                        rem_neg <= sign_a;
                        cnt     <= '0;
                        if (op_div && (src_b == '0)) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            hi_out      <= src_a;
                            lo_out      <= '1;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= CALC;
                            dsr   <= op_div ? mag_b : mag_a;
                            acc   <= {{DATA_W{1'b0}},
                                      (op_div ? mag_a : mag_b)};
                        end
                    end
                end
                CALC: begin
                    if (cancel) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(DATA_W - 1)) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            div_by_zero <= 1'b0;
                            if (is_div) begin
                                hi_out <= rem_fix;
                                lo_out <= quo_fix;
                            end else begin
                                hi_out <= prod_fix[2*DATA_W-1:DATA_W];
                                lo_out <= prod_fix[DATA_W-1:0];
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Directed bench for md_seq_ctrl: vector table plus
// cancel, reset and handshake corner sequences.
module tb_md_seq_ctrl;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        div_by_zero;

    int checks;
    int errors;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    md_seq_ctrl #(.DATA_W(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .cancel      (cancel),
        .stall_req   (stall_req),
        .busy        (busy),
        .done        (done),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with start low.
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        int bad;
        logic st_done;
        start = 1'b1;
        op    = v.op;
        src_a = v.a;
        src_b = v.b;
        #1;
        chk({tag, " stall_c0"}, 64'(stall_req), 64'd1);
        lat     = 99;
        st_done = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) chk({tag, " busy_c1"}, 64'(busy), 64'd1);
            if (done) begin
                lat     = c;
                st_done = stall_req;
                break;
            end
            src_a = $urandom;
            src_b = $urandom;
            op    = 2'($urandom);
        end
        chk({tag, " latency"}, 64'(lat), 64'(v.lat));
        chk({tag, " hi"}, 64'(hi_out), 64'(v.hi));
        chk({tag, " lo"}, 64'(lo_out), 64'(v.lo));
        chk({tag, " dbz"}, 64'(div_by_zero), 64'(v.dbz));
        chk({tag, " stall_done"}, 64'(st_done), 64'd0);
        start = 1'b0;
        bad   = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) bad++;
        end
        chk({tag, " one_done"}, 64'(bad), 64'd0);
    endtask

    initial begin
        int bad;
        vec_t v;
        checks = 0;
        errors = 0;

        vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005,
                     32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33};
        vecs[1]  = '{2'b11, 32'd100, 32'd7,
                     32'h00000002, 32'h0000000E, 1'b0, 33};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'd2,
                     32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vecs[3]  = '{2'b11, 32'd5, 32'd0,
                     32'h00000005, 32'hFFFFFFFF, 1'b1, 1};
        vecs[4]  = '{2'b01, 32'h00010000, 32'h00010000,
                     32'h00000001, 32'h00000000, 1'b0, 33};
        vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF,
                     32'h00000000, 32'h80000000, 1'b0, 33};
        vecs[6]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
        vecs[7]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     32'h00000000, 32'h00000001, 1'b0, 33};
        vecs[8]  = '{2'b10, 32'd7, 32'hFFFFFFFE,
                     32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
        vecs[9]  = '{2'b10, 32'hFFFFFFF8, 32'd0,
                     32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 1};
        vecs[10] = '{2'b00, 32'h7FFFFFFF, 32'd2,
                     32'h00000000, 32'hFFFFFFFE, 1'b0, 33};
        vecs[11] = '{2'b00, 32'h80000000, 32'h80000000,
                     32'h40000000, 32'h00000000, 1'b0, 33};
        vecs[12] = '{2'b11, 32'hFFFFFFFF, 32'd1,
                     32'h00000000, 32'hFFFFFFFF, 1'b0, 33};

        resetn = 1'b0;
        start  = 1'b1;
        op     = 2'b00;
        src_a  = 32'd3;
        src_b  = 32'd4;
        cancel = 1'b0;
        #22;
        chk("rst stall_req", 64'(stall_req), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst hilo", {hi_out, lo_out}, 64'd0);
        chk("rst dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        start  = 1'b0;
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // start together with cancel in IDLE: nothing accepted
        start  = 1'b1;
        cancel = 1'b1;
        op     = 2'b01;
        src_a  = 32'd9;
        src_b  = 32'd9;
        #1;
        chk("cxl_idle stall", 64'(stall_req), 64'd0);
        @(negedge clk);
        chk("cxl_idle busy", 64'(busy), 64'd0);
        start  = 1'b0;
        cancel = 1'b0;
        @(negedge clk);

        // cancel at CALC cycle 10, then immediate MULTU 6*7
        start = 1'b1;
        op    = 2'b00;
        src_a = 32'd1234;
        src_b = 32'd5678;
        repeat (10) @(negedge clk);
        chk("cxl_calc busy10", 64'(busy), 64'd1);
        cancel = 1'b1;
        start  = 1'b0;
        @(negedge clk);
        cancel = 1'b0;
        chk("cxl_calc busy", 64'(busy), 64'd0);
        chk("cxl_calc stall", 64'(stall_req), 64'd0);
        chk("cxl_calc done", 64'(done), 64'd0);
        chk("cxl_calc hilo", {hi_out, lo_out},
            {vecs[12].hi, vecs[12].lo});
        v = '{2'b01, 32'd6, 32'd7, 32'd0, 32'h0000002A, 1'b0, 33};
        run_vec(v, "post_cxl");

        // reset mid-CALC: async clear, no late done, clean next op
        start = 1'b1;
        op    = 2'b01;
        src_a = 32'hDEADBEEF;
        src_b = 32'h12345678;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("rst_mid busy", 64'(busy), 64'd0);
        chk("rst_mid stall", 64'(stall_req), 64'd0);
        chk("rst_mid done", 64'(done), 64'd0);
        chk("rst_mid hilo", {hi_out, lo_out}, 64'd0);
        @(negedge clk);
        start  = 1'b0;
        resetn = 1'b1;
        bad    = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) bad++;
        end
        chk("rst_mid no_done", 64'(bad), 64'd0);
        run_vec(vecs[1], "post_rst");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
